// File: rtl/dac_frame_scheduler.sv
// Four-channel round-robin sample scheduler feeding the DAC serializer.
// One frame in flight at a time, sequenced through a start/busy handshake.
module dac_frame_scheduler #(
  parameter int         DATA_W = 12,
  parameter logic [1:0] CMD    = 2'b01
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [4*DATA_W-1:0]   ch_data,
  input  logic [3:0]            ch_valid,
  output logic [3:0]            ch_ready,
  output logic [15:0]           dac_word,
  output logic                  dac_start,
  input  logic                  dac_busy,
  output logic [15:0]           frame_count,
  output logic                  active
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_e;

  state_e            state_q;
  logic [3:0]        buf_full_q;
  logic [3:0]        buf_full_d;
  logic [DATA_W-1:0] buf_data_q [4];
  logic [1:0]        rr_q;
  logic [1:0]        sel_q;
  logic [15:0]       word_q;
  logic              start_q;
  logic [15:0]       count_q;
  logic              active_q;

  logic [1:0]        win;
  logic [1:0]        idx;
  logic              grant;
  logic              done;

  assign ch_ready    = ~buf_full_q;
  assign dac_word    = word_q;
  assign dac_start   = start_q;
  assign frame_count = count_q;
  assign active      = active_q;

  // Walk the search order backwards so the earliest full slot wins.
  always_comb begin
    win = rr_q;
    idx = rr_q;
    for (int k = 3; k >= 0; k--) begin
      idx = rr_q + 2'(k);
      if (buf_full_q[idx]) win = idx;
    end
  end

  assign grant = (state_q == IDLE) && enable
              && (|buf_full_q);
  assign done  = (state_q == WAIT_DONE) && !dac_busy;

  always_comb begin
    buf_full_d = buf_full_q | ch_valid;
    if (done) buf_full_d[sel_q] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_full_q <= '0;
      for (int i = 0; i < 4; i++)
        buf_data_q[i] <= '0;
    end else begin
      buf_full_q <= buf_full_d;
      for (int i = 0; i < 4; i++)
        if (ch_valid[i] && !buf_full_q[i])
          buf_data_q[i] <= ch_data[DATA_W*i +: DATA_W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      sel_q    <= '0;
      word_q   <= '0;
      start_q  <= 1'b0;
      count_q  <= '0;
      active_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant) begin
            sel_q    <= win;
            rr_q     <= win + 2'd1;
            word_q   <= {CMD, win, buf_data_q[win]};
            start_q  <= 1'b1;
            active_q <= 1'b1;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          start_q <= 1'b0;
          state_q <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (dac_busy) state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (done) begin
            count_q  <= count_q + 16'd1;
            active_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// Directed bench for dac_frame_scheduler with a 17-cycle busy
// serializer model and a log of issued words.
module tb_dac_frame_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [47:0] ch_data;
  logic [3:0]  ch_valid;
  logic [3:0]  ch_ready;
  logic [15:0] dac_word;
  logic        dac_start;
  logic        dac_busy;
  logic [15:0] frame_count;
  logic        active;

  int checks = 0;
  int errors = 0;
  int busy_cnt;
  int sbusy;
  int n;
  logic [15:0] grants [$];

  dac_frame_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .ch_data    (ch_data),
    .ch_valid   (ch_valid),
    .ch_ready   (ch_ready),
    .dac_word   (dac_word),
    .dac_start  (dac_start),
    .dac_busy   (dac_busy),
    .frame_count(frame_count),
    .active     (active)
  );

  always #5 clk = ~clk;

  assign dac_busy = (busy_cnt != 0);

  always @(posedge clk or posedge reset) begin
    if (reset) busy_cnt <= 0;
    else if (dac_start) busy_cnt <= 17;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  always @(posedge clk) begin
    if (!reset && dac_start) begin
      grants.push_back(dac_word);
      if (dac_busy) sbusy <= sbusy + 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_fc(input string tag,
                         input logic [15:0] tgt,
                         input int lim,
                         output int cnt);
    cnt = 0;
    while (frame_count != tgt && cnt < lim) begin
      @(negedge clk);
      cnt++;
    end
    chk(tag, frame_count, tgt);
  endtask

  task automatic wait_busy(input string tag);
    int c;
    c = 0;
    while (!dac_busy && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk(tag, dac_busy, 1);
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset    = 1'b1;
    ch_valid = '0;
    @(negedge clk);
    reset = 1'b0;
    grants.delete();
    sbusy = 0;
  endtask

  initial begin
    reset    = 1'b1;
    enable   = 1'b1;
    ch_valid = '0;
    ch_data  = '0;
    sbusy    = 0;
    cyc(2);
    chk("rst_ready", ch_ready, 4'hF);
    chk("rst_word", dac_word, 16'h0);
    chk("rst_start", dac_start, 0);
    chk("rst_count", frame_count, 16'h0);
    chk("rst_active", active, 0);
    reset = 1'b0;
    cyc(1);

    // single sample on ch 2
    ch_valid[2]     = 1'b1;
    ch_data[35:24]  = 12'hABC;
    @(negedge clk);
    ch_valid = '0;
    chk("t1_ready_lo", ch_ready, 4'b1011);
    chk("t1_start_e0", dac_start, 0);
    @(negedge clk);
    chk("t1_word", dac_word, 16'h6ABC);
    chk("t1_start_e1", dac_start, 1);
    chk("t1_active", active, 1);
    @(negedge clk);
    chk("t1_start_e2", dac_start, 0);
    wait_fc("t1_count", 16'd1, 60, n);
    chk("t1_latency", n, 18);
    chk("t1_ready_hi", ch_ready, 4'hF);
    chk("t1_nstart", grants.size(), 1);

    // round robin from rr = 0
    do_reset();
    ch_valid = 4'hF;
    ch_data  = {12'h004, 12'h003,
                12'h002, 12'h001};
    @(negedge clk);
    ch_valid = '0;
    wait_fc("t2_count", 16'd4, 200, n);
    chk("t2_n", grants.size(), 4);
    chk("t2_g0", grants[0], 16'h4001);
    chk("t2_g1", grants[1], 16'h5002);
    chk("t2_g2", grants[2], 16'h6003);
    chk("t2_g3", grants[3], 16'h7004);
    chk("t2_sbusy", sbusy, 0);

    // fairness: ch 0 always refilled
    grants.delete();
    ch_valid[0]    = 1'b1;
    ch_data[11:0]  = 12'h111;
    cyc(4);
    ch_valid[3]    = 1'b1;
    ch_data[47:36] = 12'h333;
    @(negedge clk);
    ch_valid[3] = 1'b0;
    wait_fc("t3_count", 16'd7, 200, n);
    ch_valid = '0;
    chk("t3_g0", grants[0], 16'h4111);
    chk("t3_g1", grants[1], 16'h7333);
    chk("t3_g2", grants[2], 16'h4111);
    chk("t3_sbusy", sbusy, 0);

    // backpressure on ch 1
    do_reset();
    ch_valid[1]    = 1'b1;
    ch_data[23:12] = 12'h155;
    @(negedge clk);
    ch_data[23:12] = 12'h2AA;
    @(negedge clk);
    chk("t4_word", dac_word, 16'h5155);
    chk("t4_ready", ch_ready[1], 0);
    cyc(4);
    chk("t4_word_hold", dac_word, 16'h5155);
    chk("t4_ready_all", ch_ready, 4'b1101);
    ch_valid = '0;
    wait_fc("t4_count", 16'd1, 100, n);
    cyc(5);
    chk("t4_count_hold", frame_count, 16'd1);
    chk("t4_idle", active, 0);
    chk("t4_n", grants.size(), 1);
    chk("t4_ready_end", ch_ready, 4'hF);

    // enable dropped in WAIT_DONE
    do_reset();
    ch_valid      = 4'b0011;
    ch_data[11:0] = 12'h00A;
    ch_data[23:12] = 12'h00B;
    @(negedge clk);
    ch_valid = '0;
    wait_busy("t5_busy");
    @(negedge clk);
    enable = 1'b0;
    wait_fc("t5_count", 16'd1, 60, n);
    cyc(30);
    chk("t5_count_hold", frame_count, 16'd1);
    chk("t5_idle", active, 0);
    chk("t5_n", grants.size(), 1);
    chk("t5_word_hold", dac_word, 16'h400A);
    enable = 1'b1;
    @(negedge clk);
    chk("t5_regrant", dac_start, 1);
    chk("t5_word2", dac_word, 16'h500B);

    // asynchronous reset in WAIT_DONE
    wait_busy("t6_busy");
    @(negedge clk);
    ch_valid[2]    = 1'b1;
    ch_data[35:24] = 12'h777;
    @(negedge clk);
    ch_valid = '0;
    chk("t6_ready_pre", ch_ready, 4'b1001);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_ready", ch_ready, 4'hF);
    chk("t6_word", dac_word, 16'h0);
    chk("t6_start", dac_start, 0);
    chk("t6_count", frame_count, 16'h0);
    chk("t6_active", active, 0);
    @(negedge clk);
    reset = 1'b0;
    cyc(3);
    chk("t6_post_active", active, 0);
    chk("t6_post_start", dac_start, 0);
    chk("t6_post_count", frame_count, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
